// File: rtl/strand_engine_multi.sv
// LED strand engine: WS2811 NRZ or WS2801 clock+data, selected per frame.
// Pixels stream from frame-buffer RAM with a one-pixel prefetch.
module strand_engine_multi #(
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int BIT_CYCLES      = 63,
  parameter int T0H_CYCLES      = 20,
  parameter int T1H_CYCLES      = 40,
  parameter int SPI_HALF_CYCLES = 25,
  parameter int RESET_CYCLES    = 2500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [MEM_ADDR_WIDTH-1:0] strand_offset,
  input  logic [MEM_ADDR_WIDTH:0]   strand_length,
  output logic                      mem_rd,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [23:0]               mem_data,
  output logic                      data_out,
  output logic                      clk_out,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int SPI_CELL = 2 * SPI_HALF_CYCLES;
  localparam int CELL_MAX =
    (BIT_CYCLES > SPI_CELL) ? BIT_CYCLES : SPI_CELL;
  localparam int CW = $clog2(CELL_MAX + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_LATCH, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic           mode_r;
  logic [AW-1:0]  off_r;
  logic [AW:0]    len_r;
  logic [AW:0]    pix_r;
  logic [23:0]    shreg;
  logic [23:0]    hold;
  logic           hold_pend;
  logic [4:0]     bit_r;
  logic [CW-1:0]  cell_r;
  logic [RW-1:0]  lat_r;
  logic           zdone;

  logic           accept;
  logic           cell_end;
  logic           pix_end;
  logic           more;
  logic           prefetch;
  logic           lat_end;
  logic [CW-1:0]  cell_last;
  logic [CW-1:0]  high_len;

  assign accept    = start && (strand_length != '0);
  assign cell_last = mode_r ? CW'(BIT_CYCLES - 1)
                            : CW'(SPI_CELL - 1);
  assign high_len  = shreg[23] ? CW'(T1H_CYCLES)
                               : CW'(T0H_CYCLES);
  assign cell_end  = (cell_r == cell_last);
  assign pix_end   = cell_end && (bit_r == 5'd23);
  assign more      = (pix_r + (AW+1)'(1)) < len_r;
  assign lat_end   = (lat_r == RW'(RESET_CYCLES - 1));
  // Next pixel is requested at the very start of the current one.
  assign prefetch  = (state == S_SHIFT) && (bit_r == 5'd0)
                  && (cell_r == '0) && more;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_FETCH;
      S_FETCH: state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT: if (pix_end && !more) state_nx = S_LATCH;
      S_LATCH: if (lat_end) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE) || zdone;
    mem_rd   = (state == S_FETCH) || prefetch;
    mem_addr = '0;
    data_out = 1'b0;
    clk_out  = 1'b0;
    if (state == S_FETCH)
      mem_addr = off_r;
    else if (prefetch)
      mem_addr = off_r + pix_r[AW-1:0] + AW'(1);
    if (state == S_SHIFT) begin
      if (mode_r) begin
        data_out = (cell_r < high_len);
      end else begin
        data_out = shreg[23];
        clk_out  = (cell_r >= CW'(SPI_HALF_CYCLES));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r    <= 1'b0;
      off_r     <= '0;
      len_r     <= '0;
      pix_r     <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_pend <= 1'b0;
      bit_r     <= '0;
      cell_r    <= '0;
      lat_r     <= '0;
      zdone     <= 1'b0;
    end else begin
      zdone     <= (state == S_IDLE) && start
                && (strand_length == '0);
      hold_pend <= prefetch;
      if (hold_pend) hold <= mem_data;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            mode_r <= mode;
            off_r  <= strand_offset;
            len_r  <= strand_length;
            pix_r  <= '0;
          end
        end
        S_LOAD: begin
          shreg  <= mem_data;
          bit_r  <= '0;
          cell_r <= '0;
        end
        S_SHIFT: begin
          if (cell_end) begin
            cell_r <= '0;
            if (bit_r == 5'd23) begin
              bit_r <= '0;
              pix_r <= pix_r + (AW+1)'(1);
              shreg <= hold;
            end else begin
              bit_r <= bit_r + 5'd1;
              shreg <= {shreg[22:0], 1'b0};
            end
          end else begin
            cell_r <= cell_r + CW'(1);
          end
        end
        S_LATCH: lat_r <= lat_end ? '0 : lat_r + RW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_strand_engine_multi.sv
// Bench for strand_engine_multi: per-cycle waveform compare against
// a frame model built from pixel/bit/cell timing rules.
module tb_strand_engine_multi;

  localparam int AW = 4;
  localparam int BITC = 8;
  localparam int T0H = 2;
  localparam int T1H = 5;
  localparam int HALF = 2;
  localparam int RST = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] strand_offset = '0;
  logic [AW:0]   strand_length = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_data = '0;
  logic          data_out;
  logic          clk_out;
  logic          busy;
  logic          done;

  logic [23:0] mem [16];
  int total = 0;
  int bad = 0;

  strand_engine_multi #(
    .MEM_ADDR_WIDTH(AW), .BIT_CYCLES(BITC),
    .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .SPI_HALF_CYCLES(HALF), .RESET_CYCLES(RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .strand_offset(strand_offset), .strand_length(strand_length),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .data_out(data_out), .clk_out(clk_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd) mem_data <= mem[mem_addr];

  function automatic logic [8:0] obs_vec();
    logic [3:0] a;
    a = mem_rd ? mem_addr : 4'd0;
    return {busy, done, mem_rd, a, data_out, clk_out};
  endfunction

  // Called at a negedge; start is presented for the following posedge.
  task automatic run_frame(input bit m, input int off, input int len,
                           input bit junk, input bit done_start);
    logic [8:0] q[$];
    logic [23:0] px;
    logic [3:0] a;
    logic [8:0] o;
    bit rd, d, c, bv;
    int cl, rdc, offv;
    cl = m ? BITC : 2 * HALF;
    offv = off;
    a = offv[3:0];
    q.push_back({1'b1, 1'b0, 1'b1, a, 1'b0, 1'b0});
    q.push_back(9'b100000000);
    for (int n = 0; n < len; n++) begin
      px = mem[(off + n) % 16];
      for (int b = 23; b >= 0; b--) begin
        bv = px[b];
        for (int k = 0; k < cl; k++) begin
          rd = (b == 23) && (k == 0) && (n < len - 1);
          offv = (off + n + 1) % 16;
          a = rd ? offv[3:0] : 4'd0;
          d = m ? (k < (bv ? T1H : T0H)) : bv;
          c = m ? 1'b0 : (k >= HALF);
          q.push_back({1'b1, 1'b0, rd, a, d, c});
        end
      end
    end
    for (int i = 0; i < RST; i++) q.push_back(9'b100000000);
    q.push_back(9'b110000000);
    mode = m;
    strand_offset = AW'(off);
    strand_length = (AW+1)'(len);
    start = 1'b1;
    rdc = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      o = obs_vec();
      if (mem_rd) rdc++;
      total++;
      if (o !== q[i]) begin
        bad++;
        $display("FAIL frame m=%0d off=%0d cyc=%0d got=%b exp=%b",
                 m, off, i, o, q[i]);
      end
      if (junk && i > 2 && i < q.size() - 30
          && $urandom_range(0, 30) == 0) begin
        start = 1'b1;
        mode = ~mode;
        strand_offset = AW'($urandom);
        strand_length = (AW+1)'($urandom);
      end
    end
    total++;
    if (rdc != len) begin
      bad++;
      $display("FAIL rd_count got=%0d exp=%0d", rdc, len);
    end
    if (done_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({busy, done, mem_rd} !== 3'b000) begin
        bad++;
        $display("FAIL done_cycle_start got=%b exp=000",
                 {busy, done, mem_rd});
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (obs_vec() !== 9'd0) begin
      bad++;
      $display("FAIL reset_state got=%b exp=0", obs_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ws2811_directed();
    mem[0] = 24'hA50000;
    @(negedge clk);
    run_frame(1'b1, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_ws2801_directed();
    mem[5] = 24'hFFFFFF;
    mem[6] = 24'h000001;
    @(negedge clk);
    run_frame(1'b0, 5, 2, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    @(negedge clk);
    run_frame(1'b0, 14, 4, 1'b0, 1'b0);
  endtask

  task automatic test_max_len();
    @(negedge clk);
    run_frame(1'b0, 3, 16, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    strand_length = '0;
    strand_offset = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (obs_vec() !== 9'b010000000) begin
      bad++;
      $display("FAIL zero_len_done got=%b exp=010000000", obs_vec());
    end
    @(negedge clk);
    total++;
    if (obs_vec() !== 9'd0) begin
      bad++;
      $display("FAIL zero_len_after got=%b exp=0", obs_vec());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    @(negedge clk);
    run_frame(1'b1, $urandom_range(0, 15), 2, 1'b1, 1'b1);
    run_frame(1'b0, $urandom_range(0, 15), 3, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
      @(negedge clk);
      run_frame(1'($urandom), $urandom_range(0, 15),
                $urandom_range(1, 4), 1'b0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    int errs;
    mem[2] = 24'h800000;
    @(negedge clk);
    mode = 1'b1;
    strand_offset = 4'd2;
    strand_length = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (data_out !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_data got=%b exp=1", data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({data_out, clk_out, busy, done, mem_rd} !== 5'd0) begin
      bad++;
      $display("FAIL async_reset got=%b exp=00000",
               {data_out, clk_out, busy, done, mem_rd});
    end
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (6) begin
      @(negedge clk);
      if (obs_vec() !== 9'd0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL post_reset_idle got=%0d nonidle exp=0", errs);
    end
    mem[9] = 24'h5A5A5A;
    @(negedge clk);
    run_frame(1'b1, 9, 1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_ws2811_directed();
    test_ws2801_directed();
    test_wrap();
    test_max_len();
    test_zero_len();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
